// File: rtl/lockstep_pkg.sv
// Shared types and helpers for the lockstep golden-vs-netlist checker.
//   lockstep_state_e : checker FSM states (settle window, running, halted)
//   sat_inc          : saturating increment for counters up to SAT_W bits wide
package lockstep_pkg;

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALT   = 2'd2
  } lockstep_state_e;

  localparam int unsigned SAT_W = 64;

  // Increments v unless it already holds the all-ones value of a w-bit
  // counter. Callers zero-extend their counter in and truncate the result.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input int unsigned       w);
    logic [SAT_W-1:0] top;
    top = (SAT_W'(1) << w) - SAT_W'(1);
    sat_inc = (v >= top) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/lockstep_align_delay.sv
// Fixed-length delay line that aligns the golden stream with the netlist.
// Advances every cycle; cleared to zero by reset. DEPTH must be >= 1
// (the zero-delay case is a plain wire in the parent).
//   clk, rst : clock, synchronous active-high reset
//   d        : W-bit input sample
//   q        : d delayed by DEPTH cycles
module lockstep_align_delay #(
  parameter int unsigned W     = 128,
  parameter int unsigned DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/lockstep_compare_checker.sv
// Cycle-by-cycle comparison of LANES golden lanes against netlist lanes.
// Golden is delayed ALIGN_DEPTH cycles, compares are suppressed for SETTLE
// cycles after reset, counters saturate, and the first mismatch is captured.
//   clk, rst      : clock, synchronous active-high reset
//   clear         : zero counters, sticky flags and capture (settle not restarted)
//   in_valid      : netlist sample valid
//   golden        : golden lanes, lane k at [k*WIDTH +: WIDTH]
//   netlist       : netlist lanes, same packing
//   mask          : per-bit compare enable, shared by all lanes
//   mismatch      : registered one-cycle pulse on a failing compare
//   lane_err      : sticky per-lane failure flags
//   compare_cnt   : saturating count of compares performed
//   mismatch_cnt  : saturating count of failing compares
//   first_valid   : capture registers are loaded
//   first_lane    : lowest failing lane of the first mismatch
//   first_golden  : golden value of that lane
//   first_netlist : netlist value of that lane
//   first_index   : compare_cnt value before the first failing compare
//   pass          : at least one compare done and none failed
module lockstep_compare_checker
  import lockstep_pkg::*;
#(
  parameter int unsigned WIDTH         = 32,
  parameter int unsigned LANES         = 4,
  parameter int unsigned ALIGN_DEPTH   = 0,
  parameter int unsigned SETTLE        = 2,
  parameter int unsigned CNT_W         = 16,
  parameter bit          STOP_ON_FIRST = 1'b0,
  localparam int unsigned LANE_W       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] golden,
  input  logic [LANES*WIDTH-1:0] netlist,
  input  logic [WIDTH-1:0]       mask,
  output logic                   mismatch,
  output logic [LANES-1:0]       lane_err,
  output logic [CNT_W-1:0]       compare_cnt,
  output logic [CNT_W-1:0]       mismatch_cnt,
  output logic                   first_valid,
  output logic [LANE_W-1:0]      first_lane,
  output logic [WIDTH-1:0]       first_golden,
  output logic [WIDTH-1:0]       first_netlist,
  output logic [CNT_W-1:0]       first_index,
  output logic                   pass
);

  localparam int unsigned     SET_W    = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SET_W-1:0] SET_INIT = SET_W'(SETTLE);

  lockstep_state_e           state_q, state_d;
  logic [SET_W-1:0]          settle_q, settle_d;
  logic [LANES*WIDTH-1:0]    golden_d;
  logic [LANES-1:0]          lane_fail;
  logic                      any_fail;
  logic                      do_cmp;
  logic [LANE_W-1:0]         low_lane;
  logic [WIDTH-1:0]          low_golden, low_netlist;
  logic [CNT_W-1:0]          cnt_d, mcnt_d;

  if (ALIGN_DEPTH == 0) begin : g_no_align
    assign golden_d = golden;
  end else begin : g_align
    lockstep_align_delay #(
      .W     (LANES * WIDTH),
      .DEPTH (ALIGN_DEPTH)
    ) u_align (
      .clk (clk),
      .rst (rst),
      .d   (golden),
      .q   (golden_d)
    );
  end

  // Per-lane masked compare and lowest-index failing lane select.
  always_comb begin
    lane_fail   = '0;
    low_lane    = '0;
    low_golden  = '0;
    low_netlist = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_fail[k] = |((golden_d[k*WIDTH +: WIDTH] ^ netlist[k*WIDTH +: WIDTH]) & mask);
    end
    // Scan high to low so the last hit written is the lowest lane.
    for (int unsigned k = LANES; k > 0; k--) begin
      if (lane_fail[k-1]) begin
        low_lane    = LANE_W'(k - 1);
        low_golden  = golden_d[(k-1)*WIDTH +: WIDTH];
        low_netlist = netlist[(k-1)*WIDTH +: WIDTH];
      end
    end
  end

  assign any_fail = |lane_fail;

  // Clear has priority: a compare in the same cycle is discarded.
  assign do_cmp = (state_q == ST_RUN) && in_valid && !clear;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      ST_SETTLE: begin
        if (settle_q <= SET_W'(1)) state_d = ST_RUN;
        if (settle_q != '0) settle_d = settle_q - SET_W'(1);
      end
      ST_RUN: begin
        if (STOP_ON_FIRST && do_cmp && any_fail) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (clear) state_d = ST_RUN;
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_comb begin
    cnt_d  = compare_cnt;
    mcnt_d = mismatch_cnt;
    if (clear) begin
      cnt_d  = '0;
      mcnt_d = '0;
    end else if (do_cmp) begin
      cnt_d = CNT_W'(sat_inc(SAT_W'(compare_cnt), CNT_W));
      if (any_fail) mcnt_d = CNT_W'(sat_inc(SAT_W'(mismatch_cnt), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SETTLE;
      settle_q      <= SET_INIT;
      mismatch      <= 1'b0;
      lane_err      <= '0;
      compare_cnt   <= '0;
      mismatch_cnt  <= '0;
      first_valid   <= 1'b0;
      first_lane    <= '0;
      first_golden  <= '0;
      first_netlist <= '0;
      first_index   <= '0;
      pass          <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      compare_cnt  <= cnt_d;
      mismatch_cnt <= mcnt_d;
      pass         <= (cnt_d != '0) && (mcnt_d == '0);
      mismatch     <= do_cmp && any_fail;
      if (clear) begin
        lane_err      <= '0;
        first_valid   <= 1'b0;
        first_lane    <= '0;
        first_golden  <= '0;
        first_netlist <= '0;
        first_index   <= '0;
      end else if (do_cmp && any_fail) begin
        lane_err <= lane_err | lane_fail;
        if (!first_valid) begin
          first_valid   <= 1'b1;
          first_lane    <= low_lane;
          first_golden  <= low_golden;
          first_netlist <= low_netlist;
          first_index   <= compare_cnt;
        end
      end
    end
  end

endmodule

// File: tb/tb_lockstep_compare_checker.sv
// Scoreboard bench for lockstep_compare_checker. Five instances run side by side:
//   u0 default, u1 ALIGN_DEPTH=3, u2 ALIGN_DEPTH=2, u3 STOP_ON_FIRST=1, u4 CNT_W=4.
// u1/u2 always see golden and golden delayed by 3 cycles as netlist.
module tb_lockstep_compare_checker;

  localparam int unsigned NI = 5;
  localparam int unsigned GW = 128;
  localparam logic [NI-1:0][3:0] ALN = {4'd0, 4'd0, 4'd2, 4'd3, 4'd0};
  localparam logic [NI-1:0][4:0] CWS = {5'd4, 5'd16, 5'd16, 5'd16, 5'd16};
  localparam logic [NI-1:0]      STP = 5'b01000;

  typedef struct {
    logic        mm;
    logic [3:0]  le;
    logic [15:0] cc, mc, fi;
    logic        fv, ps;
    logic [1:0]  fl;
    logic [31:0] fg, fn;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_v  [NI];
  logic          clr_v  [NI];
  logic          vld_v  [NI];
  logic [GW-1:0] gold_v [NI];
  logic [GW-1:0] net_v  [NI];
  logic [31:0]   mask_v [NI];

  wire [NI-1:0]    mm_w, fv_w, ps_w;
  wire [NI*4-1:0]  le_w;
  wire [NI*16-1:0] cc_w, mc_w, fi_w;
  wire [NI*2-1:0]  fl_w;
  wire [NI*32-1:0] fg_w, fn_w;

  for (genvar i = 0; i < NI; i++) begin : g_dut
    localparam int unsigned CW = 32'(CWS[i]);
    logic [CW-1:0] cc, mc, fi;
    lockstep_compare_checker #(
      .WIDTH         (32),
      .LANES         (4),
      .ALIGN_DEPTH   (32'(ALN[i])),
      .SETTLE        (2),
      .CNT_W         (CW),
      .STOP_ON_FIRST (STP[i])
    ) u_dut (
      .clk           (clk),
      .rst           (rst_v[i]),
      .clear         (clr_v[i]),
      .in_valid      (vld_v[i]),
      .golden        (gold_v[i]),
      .netlist       (net_v[i]),
      .mask          (mask_v[i]),
      .mismatch      (mm_w[i]),
      .lane_err      (le_w[i*4 +: 4]),
      .compare_cnt   (cc),
      .mismatch_cnt  (mc),
      .first_valid   (fv_w[i]),
      .first_lane    (fl_w[i*2 +: 2]),
      .first_golden  (fg_w[i*32 +: 32]),
      .first_netlist (fn_w[i*32 +: 32]),
      .first_index   (fi),
      .pass          (ps_w[i])
    );
    assign cc_w[i*16 +: 16] = 16'(cc);
    assign mc_w[i*16 +: 16] = 16'(mc);
    assign fi_w[i*16 +: 16] = 16'(fi);
  end

  // Reference model state: 0 settle, 1 run, 2 halt.
  int unsigned   m_st   [NI];
  int unsigned   m_sc   [NI];
  logic [GW-1:0] m_hist [NI][16];
  exp_t          m_e    [NI];
  exp_t          sbq    [$];
  int unsigned   n_vec, n_miss;
  logic [GW-1:0] h1, h2, h3;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [GW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v, input int unsigned i);
    logic [15:0] mx;
    mx = (CWS[i] == 5'd4) ? 16'h000F : 16'hFFFF;
    return (v == mx) ? v : v + 16'd1;
  endfunction

  task automatic model_step(input int unsigned i);
    exp_t          e;
    int unsigned   st, al;
    logic [GW-1:0] gd;
    logic [3:0]    fail;
    logic          cmp, found;
    logic [1:0]    lo;
    e = m_e[i];
    if (rst_v[i]) begin
      e = '{default: '0};
      m_st[i] = 0;
      m_sc[i] = 2;
      for (int j = 0; j < 16; j++) m_hist[i][j] = '0;
    end else begin
      st  = m_st[i];
      al  = 32'(ALN[i]);
      gd  = (al == 0) ? gold_v[i] : m_hist[i][4'(al - 1)];
      cmp = (st == 1) && vld_v[i] && !clr_v[i];
      found = 1'b0;
      lo = 2'd0;
      for (int k = 0; k < 4; k++) begin
        fail[k] = |((gd[k*32 +: 32] ^ net_v[i][k*32 +: 32]) & mask_v[i]);
        if (fail[k] && !found) begin
          found = 1'b1;
          lo = 2'(k);
        end
      end
      e.mm = 1'b0;
      if (clr_v[i]) begin
        e = '{default: '0};
        if (st == 2) m_st[i] = 1;
      end else if (cmp) begin
        if (found) begin
          e.mm = 1'b1;
          if (!e.fv) begin
            e.fv = 1'b1;
            e.fl = lo;
            e.fi = e.cc;
            e.fg = gd[lo*32 +: 32];
            e.fn = net_v[i][lo*32 +: 32];
          end
          e.mc = sat16(e.mc, i);
          e.le = e.le | fail;
          if (STP[i]) m_st[i] = 2;
        end
        e.cc = sat16(e.cc, i);
      end
      if (st == 0) begin
        if (m_sc[i] <= 1) m_st[i] = 1;
        if (m_sc[i] != 0) m_sc[i] = m_sc[i] - 1;
      end
      e.ps = (e.cc != 16'd0) && (e.mc == 16'd0);
      for (int j = 15; j > 0; j--) m_hist[i][j] = m_hist[i][j-1];
      m_hist[i][0] = gold_v[i];
    end
    m_e[i] = e;
    sbq.push_back(e);
  endtask

  // Drive the aligned-stream pair, push expectations, clock, pop and compare.
  task automatic tick();
    logic [GW-1:0] g;
    exp_t          e;
    string         p;
    g = rst_v[1] ? '0 : rnd();
    gold_v[1] = g;  net_v[1] = h3;
    gold_v[2] = g;  net_v[2] = h3;
    h3 = h2;  h2 = h1;  h1 = g;
    for (int unsigned i = 0; i < NI; i++) model_step(i);
    @(posedge clk);
    #1;
    for (int unsigned i = 0; i < NI; i++) begin
      e = sbq.pop_front();
      p = $sformatf("u%0d.", i);
      chk({p, "mismatch"},      64'(mm_w[i]),           64'(e.mm));
      chk({p, "lane_err"},      64'(le_w[i*4 +: 4]),    64'(e.le));
      chk({p, "compare_cnt"},   64'(cc_w[i*16 +: 16]),  64'(e.cc));
      chk({p, "mismatch_cnt"},  64'(mc_w[i*16 +: 16]),  64'(e.mc));
      chk({p, "first_valid"},   64'(fv_w[i]),           64'(e.fv));
      chk({p, "first_lane"},    64'(fl_w[i*2 +: 2]),    64'(e.fl));
      chk({p, "first_golden"},  64'(fg_w[i*32 +: 32]),  64'(e.fg));
      chk({p, "first_netlist"}, 64'(fn_w[i*32 +: 32]),  64'(e.fn));
      chk({p, "first_index"},   64'(fi_w[i*16 +: 16]),  64'(e.fi));
      chk({p, "pass"},          64'(ps_w[i]),           64'(e.ps));
    end
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic [GW-1:0] bad;
    bad = '0;
    bad[2*32 + 5] = 1'b1;
    n_vec  = 0;
    n_miss = 0;
    h1 = '0;  h2 = '0;  h3 = '0;
    for (int unsigned i = 0; i < NI; i++) begin
      rst_v[i] = 1'b1;  clr_v[i] = 1'b0;  vld_v[i] = 1'b0;
      gold_v[i] = '0;   net_v[i] = '0;    mask_v[i] = '1;
      m_e[i] = '{default: '0};
      m_st[i] = 0;  m_sc[i] = 2;
      for (int j = 0; j < 16; j++) m_hist[i][j] = '0;
    end
    repeat (3) tick();
    chk("rst.u0.pass", 64'(ps_w[0]), 64'd0);
    chk("rst.u3.cnt",  64'(cc_w[48 +: 16]), 64'd0);

    for (int unsigned i = 0; i < NI; i++) rst_v[i] = 1'b0;
    vld_v[1] = 1'b1;
    vld_v[2] = 1'b1;

    // Identical streams; two settle cycles then 1000 valid samples.
    for (int t = 0; t < 1002; t++) begin
      gold_v[0] = rnd();
      net_v[0]  = gold_v[0];
      vld_v[0]  = (t >= 2);
      tick();
    end
    chk("a.u0.cnt1000",  64'(cc_w[0 +: 16]),  64'd1000);
    chk("a.u0.mm0",      64'(mc_w[0 +: 16]),  64'd0);
    chk("a.u0.pass",     64'(ps_w[0]),        64'd1);
    chk("a.u0.fv0",      64'(fv_w[0]),        64'd0);
    chk("a.u1.cnt",      64'(cc_w[16 +: 16]), 64'd1000);
    chk("a.u1.mm0",      64'(mc_w[16 +: 16]), 64'd0);
    chk("a.u2.cnt",      64'(cc_w[32 +: 16]), 64'd1000);
    chk("a.u2.mm_all",   64'(mc_w[32 +: 16]), 64'd1000);

    // u0: clear then lane 2 bit 5 corrupted on the 10th compare.
    // u3: mismatches at its 4th and 7th samples. u4: every compare fails.
    vld_v[0] = 1'b1;  vld_v[3] = 1'b1;  vld_v[4] = 1'b1;
    for (int b = 0; b < 22; b++) begin
      clr_v[0]  = (b == 0);
      gold_v[0] = rnd();
      net_v[0]  = gold_v[0] ^ ((b == 10) ? bad : '0);
      gold_v[3] = rnd();
      net_v[3]  = gold_v[3] ^ ((b == 3 || b == 6) ? GW'(1) : '0);
      gold_v[4] = rnd();
      net_v[4]  = ~gold_v[4];
      tick();
      if (b == 0) chk("b.u0.clear_wins", 64'(cc_w[0 +: 16]), 64'd0);
      if (b == 10) begin
        chk("b.u0.pulse",       64'(mm_w[0]),          64'd1);
        chk("b.u0.lane_err",    64'(le_w[0 +: 4]),     64'h4);
        chk("b.u0.first_lane",  64'(fl_w[0 +: 2]),     64'd2);
        chk("b.u0.first_index", 64'(fi_w[0 +: 16]),    64'd9);
        chk("b.u0.mm_cnt",      64'(mc_w[0 +: 16]),    64'd1);
        chk("b.u0.first_gold",  64'(fg_w[0 +: 32]),    64'(gold_v[0][64 +: 32]));
        chk("b.u0.first_net",   64'(fn_w[0 +: 32]),    64'(gold_v[0][64 +: 32] ^ 32'h20));
      end
      if (b == 11) chk("b.u0.pulse_end", 64'(mm_w[0]), 64'd0);
    end
    chk("b.u0.cnt",        64'(cc_w[0 +: 16]),  64'd21);
    chk("b.u0.pass0",      64'(ps_w[0]),        64'd0);
    chk("b.u3.halt_cnt",   64'(cc_w[48 +: 16]), 64'd4);
    chk("b.u3.halt_mm",    64'(mc_w[48 +: 16]), 64'd1);
    chk("b.u3.first_idx",  64'(fi_w[48 +: 16]), 64'd3);
    chk("b.u4.sat_cnt",    64'(cc_w[64 +: 16]), 64'd15);
    chk("b.u4.sat_mm",     64'(mc_w[64 +: 16]), 64'd15);

    // u0: masked corruption. u3: clear out of HALT. u4: reset mid-run.
    mask_v[0] = 32'hFFFF_FFDF;
    for (int c = 0; c < 14; c++) begin
      clr_v[0]  = (c == 0);
      gold_v[0] = rnd();
      net_v[0]  = gold_v[0] ^ ((c == 10) ? bad : '0);
      clr_v[3]  = (c == 0);
      gold_v[3] = rnd();
      net_v[3]  = gold_v[3];
      rst_v[4]  = (c == 2);
      gold_v[4] = rnd();
      net_v[4]  = ~gold_v[4];
      tick();
      if (c == 0) begin
        chk("c.u3.clr_cnt", 64'(cc_w[48 +: 16]), 64'd0);
        chk("c.u3.clr_mm",  64'(mc_w[48 +: 16]), 64'd0);
        chk("c.u3.clr_fv",  64'(fv_w[3]),        64'd0);
      end
      if (c == 2) begin
        chk("c.u4.rst_cnt", 64'(cc_w[64 +: 16]), 64'd0);
        chk("c.u4.rst_mm",  64'(mc_w[64 +: 16]), 64'd0);
        chk("c.u4.rst_le",  64'(le_w[16 +: 4]),  64'd0);
        chk("c.u4.rst_fv",  64'(fv_w[4]),        64'd0);
        chk("c.u4.rst_mmp", 64'(mm_w[4]),        64'd0);
      end
      if (c == 3 || c == 4) chk("c.u4.settle", 64'(cc_w[64 +: 16]), 64'd0);
      if (c == 5) chk("c.u4.resume", 64'(cc_w[64 +: 16]), 64'd1);
    end
    chk("c.u0.masked_mm", 64'(mc_w[0 +: 16]),  64'd0);
    chk("c.u0.pass",      64'(ps_w[0]),        64'd1);
    chk("c.u0.cnt",       64'(cc_w[0 +: 16]),  64'd13);
    chk("c.u3.run_cnt",   64'(cc_w[48 +: 16]), 64'd13);
    chk("c.u3.pass",      64'(ps_w[3]),        64'd1);
    chk("c.u4.cnt",       64'(cc_w[64 +: 16]), 64'd9);
    chk("c.u4.mm",        64'(mc_w[64 +: 16]), 64'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lockstep_compare_checker.md
# lockstep_compare_checker

Synthesizable, parametrised successor to the golden-vs-netlist comparison done in our post-route benches. It checks N lanes of a golden model output against the netlist output cycle by cycle, with a programmable alignment delay, a post-reset settle window, per-bit masking, saturating counters and first-mismatch capture. It sits beside the two design instances in simulation or emulation wrappers, so pass/fail is computed in hardware rather than in testbench tasks.

## Interface
- WIDTH, 32, bits per lane
- LANES, 4, number of compared lanes
- ALIGN_DEPTH, 0, cycles of delay applied to golden before compare (0..15)
- SETTLE, 2, cycles after reset release during which compares are suppressed
- CNT_W, 16, width of compare and mismatch counters
- STOP_ON_FIRST, 0, 1 = freeze all counters and captures after the first mismatch
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- clear  in  1  synchronous clear of counters, sticky flags and capture; does not restart the settle window
- in_valid  in  1  netlist sample valid this cycle
- golden  in  LANES*WIDTH  golden outputs; lane k is bits [k*WIDTH +: WIDTH]
- netlist  in  LANES*WIDTH  netlist outputs, same packing
- mask  in  WIDTH  1 = bit compared; applied to all lanes
- mismatch  out  1  one-cycle pulse, registered
- lane_err  out  LANES  sticky per-lane mismatch flags
- compare_cnt  out  CNT_W  saturating count of performed compares
- mismatch_cnt  out  CNT_W  saturating count of mismatching compares
- first_valid  out  1  capture registers hold data
- first_lane  out  $clog2(LANES) (min 1)  lowest-index failing lane of the first mismatch
- first_golden, first_netlist  out  WIDTH  values of that lane at the first mismatch
- first_index  out  CNT_W  compare_cnt value at the first mismatch
- pass  out  1  compare_cnt != 0 and mismatch_cnt == 0

## Operation
- Golden path: shift register of ALIGN_DEPTH stages, advancing every cycle regardless of in_valid. ALIGN_DEPTH=0 is a wire.
- FSM states: SETTLE, RUN, HALT. Reset enters SETTLE with settle counter = SETTLE. SETTLE decrements the counter each cycle and moves to RUN when it reaches 0; with SETTLE=0 the FSM enters RUN on the first cycle after reset. RUN goes to HALT on a mismatch only if STOP_ON_FIRST=1. HALT returns to RUN on clear.
- A compare occurs when state==RUN and in_valid=1. Lane k fails when ((golden_d[k] ^ netlist[k]) & mask) != 0.
- On a compare, compare_cnt increments. If any lane fails: mismatch_cnt increments, the failing lanes' lane_err bits set, and mismatch pulses. If first_valid=0, the block also captures the lowest failing lane, its golden and netlist values, and the pre-increment compare_cnt, then sets first_valid.
- Counters saturate at all-ones and never wrap.
- In HALT, counters, flags and captures hold. mismatch stays 0.
- If clear and a compare occur in the same cycle, clear wins and the compare is discarded.
- Reset mid-operation zeroes all outputs and restarts the settle window.

## Timing
- Every output is registered. Reset value is 0 for all outputs, and pass=0.
- Latency: the netlist sample at cycle t is compared against golden from cycle t-ALIGN_DEPTH. The result is visible at t+1.
- in_valid needs no handshake. Compares are accepted every cycle in RUN.

## Structure
- Package lockstep_pkg holds the state enum typedef (SETTLE/RUN/HALT) and a function for saturating increment.
- One sub-module, lockstep_align_delay, implements the parametrised ALIGN_DEPTH delay line.

## Test plan
- WIDTH=32, LANES=4, SETTLE=2, identical streams, 1000 random in_valid=1 cycles -> compare_cnt=1000, mismatch_cnt=0, pass=1, first_valid=0.
- Corrupt bit 5 of lane 2 on the 10th compare -> mismatch pulse one cycle later, lane_err=4'b0100, first_lane=2, first_index=9, mismatch_cnt=1.
- Same corruption with mask[5]=0 -> no mismatch, pass=1.
- ALIGN_DEPTH=3, netlist = golden delayed 3 cycles -> zero mismatches. With ALIGN_DEPTH=2 on the same streams -> mismatch_cnt equals compare_cnt for random data.
- STOP_ON_FIRST=1, two mismatches -> HALT after the first, mismatch_cnt=1, compare_cnt frozen. Pulse clear -> counters 0, state RUN.
- CNT_W=4, 20 mismatching compares -> both counters saturate at 15. Assert rst mid-run -> all outputs 0 and no compares for 2 cycles.
